// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer.
// Shift-add multiply and restoring divide over 32 iterations on one shared
// 33-bit adder, followed by a sign-fix cycle that writes HI/LO.
// MTHI/MTLO writes and divide-by-zero complete directly from IDLE.
module mdu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // Magnitude of a value when treated as signed, raw value otherwise.
    function automatic logic [31:0] f_abs(input logic [31:0] v, input logic sgn);
        f_abs = (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_acc;     // partial product high half / partial remainder
    logic [31:0] r_mq;      // multiplier -> product low half / dividend -> quotient
    logic [31:0] r_opnd;    // multiplicand / divisor magnitude
    logic        r_is_div;
    logic        r_qsign;   // product or quotient negative
    logic        r_rsign;   // remainder negative
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_sgn;
    logic [32:0] w_x;
    logic [32:0] w_y;
    logic        w_cin;
    logic [33:0] w_sum;

    assign w_accept = start & ~flush & (r_state == S_IDLE);
    assign w_sgn    = ~op[0];
    assign w_sum    = {1'b0, w_x} + {1'b0, w_y} + {33'd0, w_cin};

    // Shared adder operand selection: add multiplicand or subtract divisor.
    always_comb begin
        w_x   = {1'b0, r_acc};
        w_y   = 33'd0;
        w_cin = 1'b0;
        case (r_state)
            S_DIV: begin
                w_x   = {r_acc, r_mq[31]};
                w_y   = ~{1'b0, r_opnd};
                w_cin = 1'b1;
            end
            S_MUL: begin
                w_x   = {1'b0, r_acc};
                w_y   = r_mq[0] ? {1'b0, r_opnd} : 33'd0;
                w_cin = 1'b0;
            end
            default: begin
                w_x   = {1'b0, r_acc};
                w_y   = 33'd0;
                w_cin = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush abandons any iteration or fix cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (op == OP_MULT || op == OP_MULTU)) begin
                    w_next = S_MUL;
                end else if (w_accept && (op == OP_DIV || op == OP_DIVU) && (b != 32'd0)) begin
                    w_next = S_DIV;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 6'd31) begin
                    w_next = S_FIX;
                end else begin
                    w_next = r_state;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iterations, sign fix and HI/LO write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= 6'd0;
            r_acc    <= 32'd0;
            r_mq     <= 32'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_acc    <= 32'd0;
                                r_mq     <= f_abs(b, w_sgn);
                                r_opnd   <= f_abs(a, w_sgn);
                                r_qsign  <= w_sgn & (a[31] ^ b[31]);
                                r_rsign  <= 1'b0;
                                r_is_div <= 1'b0;
                                r_cnt    <= 6'd0;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == 32'd0) begin
                                    r_hi   <= a;
                                    r_lo   <= 32'hFFFF_FFFF;
                                    r_done <= 1'b1;
                                end else begin
                                    r_acc    <= 32'd0;
                                    r_mq     <= f_abs(a, w_sgn);
                                    r_opnd   <= f_abs(b, w_sgn);
                                    r_qsign  <= w_sgn & (a[31] ^ b[31]);
                                    r_rsign  <= w_sgn & a[31];
                                    r_is_div <= 1'b1;
                                    r_cnt    <= 6'd0;
                                end
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: r_done <= 1'b0;
                        endcase
                    end
                end
                S_MUL: begin
                    r_done <= 1'b0;
                    if (!flush) begin
                        r_acc <= w_sum[32:1];
                        r_mq  <= {w_sum[0], r_mq[31:1]};
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    r_done <= 1'b0;
                    if (!flush) begin
                        // Carry out means the shifted remainder covered the divisor.
                        r_acc <= w_sum[33] ? w_sum[31:0] : {r_acc[30:0], r_mq[31]};
                        r_mq  <= {r_mq[30:0], w_sum[33]};
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_done <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_lo <= r_qsign ? (~r_mq + 32'd1) : r_mq;
                            r_hi <= r_rsign ? (~r_acc + 32'd1) : r_acc;
                        end else begin
                            {r_hi, r_lo} <= r_qsign ? (~{r_acc, r_mq} + 64'd1) : {r_acc, r_mq};
                        end
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy  = (r_state != S_IDLE);
        stall = (r_state != S_IDLE);
        done  = r_done;
        hi    = r_hi;
        lo    = r_lo;
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed operations, expected HI/LO
// queued at issue and compared by an independent monitor on every done pulse.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    mdu_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Drive one request for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy cycles from the negedge after E0; expect 33 then a done pulse.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, 32'(n), 32'd33);
        chk1({name, "_done"}, done, 1'b1);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 hi=%h lo=%h", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({hi, lo} !== mon_exp) begin
                    errors++;
                    $display("FAIL result actual=%h_%h expected=%h_%h",
                             hi, lo, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_stall", stall, 1'b0);
        chk1("reset_done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // MULTU max * max
        exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk1("multu_stall", stall, 1'b1);
        wait_done("multu");
        chk1("multu_busy_in_done", busy, 1'b0);

        // MULT -3 * 5 = -15
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg");

        // DIV -7 / 2 -> q=-3 r=-1
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg_dividend");

        // DIV 7 / -2 -> q=-3 r=1
        exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFD});
        issue(3'b010, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_neg_divisor");

        // DIV most-negative / -1
        exp_q.push_back({32'h0000_0000, 32'h8000_0000});
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_overflow");

        // DIVU 7 / 0: immediate result, no busy
        @(negedge clk);
        exp_q.push_back({32'h0000_0007, 32'hFFFF_FFFF});
        issue(3'b011, 32'd7, 32'd0);
        chk1("div0_busy", busy, 1'b0);
        chk1("div0_done", done, 1'b1);
        @(negedge clk);
        chk1("div0_done_clear", done, 1'b0);
        chk1("div0_busy_after", busy, 1'b0);

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = 3'b100; a = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        chk1("mthi_busy", busy, 1'b0);
        chk1("mthi_done", done, 1'b0);
        op = 3'b101; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);
        chk1("mtlo_busy", busy, 1'b0);
        chk1("mtlo_done", done, 1'b0);

        // No-op encoding
        issue(3'b110, 32'hDEAD_BEEF, 32'h1);
        chk("noop_hi", hi, 32'h1234_5678);
        chk("noop_lo", lo, 32'h9ABC_DEF0);
        chk1("noop_busy", busy, 1'b0);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        issue(3'b100, 32'hCAFE_0000, 32'd0);
        flush = 1'b0;
        chk("idle_flush_hi", hi, 32'h1234_5678);
        issue(3'b001, 32'd3, 32'd3);
        flush = 1'b0;
        chk1("idle_flush_ok_busy", busy, 1'b1);
        // let that accepted MULTU complete and verify it (9)
        exp_q.push_back({32'h0000_0000, 32'h0000_0009});
        wait_done("multu_small");

        // MULT flushed mid-operation: no write, no done
        @(negedge clk);
        issue(3'b000, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        chk1("flush_busy_before", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk1("flush_busy_after", busy, 1'b0);
        chk("flush_hi_kept", hi, 32'h0000_0000);
        chk("flush_lo_kept", lo, 32'h0000_0009);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("flush_no_done", 32'(n), 32'd0);

        // MULT interrupted by reset: registers cleared, no done
        issue(3'b000, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk1("rst_mid_busy", busy, 1'b0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("rst_mid_no_done", 32'(n), 32'd0);

        // DIVU 100/7 then MULTU 3*4 with start held: back-to-back, busy start ignored
        exp_q.push_back({32'h0000_0002, 32'h0000_000E});
        exp_q.push_back({32'h0000_0000, 32'h0000_000C});
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = 3'b001; a = 32'd3; b = 32'd4;
        wait_done("divu_b2b");
        @(negedge clk);
        start = 1'b0;
        chk1("b2b_no_bubble", busy, 1'b1);
        wait_done("multu_b2b");
        @(negedge clk);
        chk1("b2b_done_clear", done, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 start  in  1  request; sampled only when the FSM is in IDLE.
REQ-005 op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 a  in  32  operand A (dividend / multiplicand / MTHI-MTLO source).
REQ-007 b  in  32  operand B (divisor / multiplier).
REQ-008 flush  in  1  abort any in-flight multiply/divide.
REQ-009 busy  out  1  high while the FSM is not in IDLE.
REQ-010 stall  out  1  pipeline hold; equals busy.
REQ-011 done  out  1  one-cycle pulse after a multiply/divide result is written.
REQ-012 hi  out  32  HI register.
REQ-013 lo  out  32  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-015 Accept edge E0: start=1, rst=1, FSM in IDLE, flush=0.
REQ-016 MULT/MULTU at E0: latch |a|, |b| (magnitudes for MULT, raw operands for MULTU), latch result sign a[31]^b[31] (MULT only), clear iteration counter; go to MUL.
REQ-017 DIV/DIVU with b!=0 at E0: latch magnitudes (DIV) or raw operands (DIVU), latch quotient sign a[31]^b[31] and remainder sign a[31] (DIV only); go to DIV.
REQ-018 MUL: one shift-add iteration per cycle using a single shared 33-bit adder; 32 iterations on edges E1..E32; go to FIX on E32.
REQ-019 DIV: one restoring shift-subtract iteration per cycle on the same shared adder; 32 iterations on edges E1..E32; go to FIX on E32.
REQ-020 FIX at E33: apply two's-complement sign correction (signed ops only); write hi/lo; go to IDLE.
REQ-021 Multiply result: {hi,lo} = full 64-bit product.
REQ-022 Divide result: lo = quotient, hi = remainder; quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0; no trap.
REQ-024 DIV/DIVU with b==0 SHALL write hi=a, lo=0xFFFFFFFF at E0; FSM stays in IDLE; done pulses the cycle after E0.
REQ-025 MTHI/MTLO at E0 SHALL write hi (or lo) = a in one cycle; busy stays low; no done.
REQ-026 No-op encodings SHALL change no state.
REQ-027 busy/stall SHALL be high for exactly the 33 cycles following E0 (through E33) for multiply/divide.
REQ-028 done SHALL be high exactly the one cycle following E33; busy is low in that cycle.
REQ-029 start while busy SHALL be ignored; the pipeline holds the request via stall.
REQ-030 start in the done cycle SHALL be accepted (back-to-back, no bubble).
REQ-031 flush=1 in MUL/DIV/FIX SHALL return the FSM to IDLE on the next edge, leave hi/lo unchanged, and suppress done.
REQ-032 flush=1 in IDLE SHALL block acceptance of start that cycle.
REQ-033 Iteration counter SHALL be 6 bits and SHALL NOT wrap within an operation.

Reset
REQ-034 rst=0 at an edge SHALL force FSM=IDLE, hi=0, lo=0, busy=0, stall=0, done=0, and counter=0.
REQ-035 Reset SHALL take priority over start, flush, and any in-flight operation; a reset mid-operation discards it without writing hi/lo.
REQ-036 Outputs SHALL be defined (reset values) from the first edge with rst=0.

Verification
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then done 1 cycle, hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=7, b=0 -> busy never high, next-cycle done, hi=7, lo=0xFFFFFFFF.
REQ-040 MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated one cycle each, busy=0 throughout, done=0.
REQ-041 MULT started, flush at cycle 10 -> busy low next cycle, hi/lo keep prior values, no done; repeat with rst=0 at cycle 10 -> hi=lo=0, no done.
REQ-042 DIVU 100/7, start held high into the done cycle with MULTU 3*4 -> first result lo=14, hi=2; second accepted with no bubble, hi=0, lo=12; start during busy ignored.
